// File: rtl/router_pkg.sv
// Shared definitions for the cell router port: widths, line levels and FSM encodings.
package router_pkg;

  localparam int   ROUTER_ADDR_W = 12;
  localparam int   ROUTER_DATA_W = 16;
  localparam logic START_BIT     = 1'b1;
  localparam logic IDLE_BIT      = 1'b0;

  typedef enum logic [2:0] {
    I_IDLE  = 3'd0,
    I_ADDR  = 3'd1,
    I_DATA  = 3'd2,
    I_PAR   = 3'd3,
    I_OFFER = 3'd4
  } inj_state_e;

  typedef enum logic [1:0] {
    E_IDLE  = 2'd0,
    E_START = 2'd1,
    E_DATA  = 2'd2,
    E_PAR   = 2'd3
  } ej_state_e;

  // Field bit-counter width; never below one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/router_cell_port_if.sv
// Parallel router-network side of a cell port: injection offer and ejection accept channels.
interface router_cell_port_if #(
  parameter int ADDR_W = router_pkg::ROUTER_ADDR_W,
  parameter int DATA_W = router_pkg::ROUTER_DATA_W
);

  logic              injValid;
  logic              injReady;
  logic [ADDR_W-1:0] injAddr;
  logic [DATA_W-1:0] injData;
  logic              ejValid;
  logic              ejReady;
  logic [DATA_W-1:0] ejData;

  // master = the cell port, slave = the router network
  modport master (
    output injValid, injAddr, injData, ejReady,
    input  injReady, ejValid, ejData
  );

  modport slave (
    input  injValid, injAddr, injData, ejReady,
    output injReady, ejValid, ejData
  );

endinterface

// File: rtl/router_bit_serializer.sv
// Ejection path: captures a router message and shifts it onto the cell line as start/data/parity.
module router_bit_serializer
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_latch,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_bit
);

  localparam int              CNT_W     = cnt_width(DATA_W, DATA_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  ej_state_e         r_st;
  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_par;
  logic              r_ready;
  logic              r_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st    <= E_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_ready <= 1'b0;
      r_bit   <= IDLE_BIT;
    end else begin
      case (r_st)
        E_IDLE: begin
          if (i_latch) r_bit <= IDLE_BIT;
          // Parity is taken at capture so the shift path stays a plain shifter.
          if (i_valid && r_ready) begin
            r_sh    <= i_data;
            r_par   <= ^i_data;
            r_ready <= 1'b0;
            r_st    <= E_START;
          end else begin
            r_ready <= 1'b1;
          end
        end
        E_START: if (i_latch) begin
          r_bit <= START_BIT;
          r_cnt <= '0;
          r_st  <= E_DATA;
        end
        E_DATA: if (i_latch) begin
          r_bit <= r_sh[0];
          r_sh  <= r_sh >> 1;
          if (r_cnt == DATA_LAST) begin
            r_cnt <= '0;
            r_st  <= E_PAR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        E_PAR: if (i_latch) begin
          r_bit <= r_par;
          r_st  <= E_IDLE;
        end
        default: r_st <= E_IDLE;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_bit   = r_bit;

endmodule

// File: rtl/router_cell_port.sv
// Router-side endpoint of a cell's bit-serial link: inline injection deserializer plus
// ejection serializer, both stepping on the shared latch strobe.
module router_cell_port
  import router_pkg::*;
#(
  parameter int ADDR_W = ROUTER_ADDR_W,
  parameter int DATA_W = ROUTER_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               latch,
  input  logic               routerData,
  output logic               handshake,
  output logic               routerIn,
  output logic               parErr,
  output logic               protoErr,
  input  logic               errClear,
  router_cell_port_if.master bus
);

  localparam int               CNT_W     = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  inj_state_e        r_ist;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr_sh;
  logic [DATA_W-1:0] r_data_sh;
  logic              r_par;
  logic              r_inj_valid;
  logic [ADDR_W-1:0] r_inj_addr;
  logic [DATA_W-1:0] r_inj_data;
  logic              r_handshake;
  logic              r_par_err;
  logic              r_proto_err;

  logic w_start;
  logic w_inj_xfer;
  logic w_par_bad;
  logic w_proto_bad;
  logic w_ej_ready;
  logic w_router_in;

  assign w_start     = latch && (routerData == START_BIT);
  assign w_inj_xfer  = r_inj_valid && bus.injReady;
  assign w_par_bad   = (r_ist == I_PAR) && latch && (r_par ^ routerData);
  assign w_proto_bad = (r_ist == I_OFFER) && w_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ist       <= I_IDLE;
      r_cnt       <= '0;
      r_addr_sh   <= '0;
      r_data_sh   <= '0;
      r_par       <= 1'b0;
      r_inj_valid <= 1'b0;
      r_inj_addr  <= '0;
      r_inj_data  <= '0;
      r_handshake <= 1'b1;
      r_par_err   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_ist)
        I_IDLE: if (w_start) begin
          r_cnt       <= '0;
          r_par       <= 1'b0;
          r_handshake <= 1'b0;
          r_ist       <= I_ADDR;
        end
        I_ADDR: if (latch) begin
          r_addr_sh <= {routerData, r_addr_sh[ADDR_W-1:1]};
          r_par     <= r_par ^ routerData;
          if (r_cnt == ADDR_LAST) begin
            r_cnt <= '0;
            r_ist <= I_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        I_DATA: if (latch) begin
          r_data_sh <= {routerData, r_data_sh[DATA_W-1:1]};
          r_par     <= r_par ^ routerData;
          if (r_cnt == DATA_LAST) begin
            r_cnt <= '0;
            r_ist <= I_PAR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        I_PAR: if (latch) begin
          if (w_par_bad) begin
            r_handshake <= 1'b1;
            r_ist       <= I_IDLE;
          end else begin
            r_inj_valid <= 1'b1;
            r_inj_addr  <= r_addr_sh;
            r_inj_data  <= r_data_sh;
            r_ist       <= I_OFFER;
          end
        end
        // Offer is latch-independent; start bits arriving here are dropped and flagged.
        I_OFFER: if (w_inj_xfer) begin
          r_inj_valid <= 1'b0;
          r_handshake <= 1'b1;
          r_ist       <= I_IDLE;
        end
        default: r_ist <= I_IDLE;
      endcase

      if (w_par_bad)     r_par_err <= 1'b1;
      else if (errClear) r_par_err <= 1'b0;

      if (w_proto_bad)   r_proto_err <= 1'b1;
      else if (errClear) r_proto_err <= 1'b0;
    end
  end

  router_bit_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_latch (latch),
    .i_valid (bus.ejValid),
    .i_data  (bus.ejData),
    .o_ready (w_ej_ready),
    .o_bit   (w_router_in)
  );

  assign bus.injValid = r_inj_valid;
  assign bus.injAddr  = r_inj_addr;
  assign bus.injData  = r_inj_data;
  assign bus.ejReady  = w_ej_ready;
  assign handshake    = r_handshake;
  assign routerIn     = w_router_in;
  assign parErr       = r_par_err;
  assign protoErr     = r_proto_err;

endmodule

// File: tb/tb_router_cell_port.sv
// Directed bench for router_cell_port: injection, parity drop, backpressure, ejection, concurrency, reset.
module tb_router_cell_port;
  import router_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset, latch, routerData, errClear;
  logic handshake, routerIn, parErr, protoErr;

  router_cell_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  router_cell_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .latch      (latch),
    .routerData (routerData),
    .handshake  (handshake),
    .routerIn   (routerIn),
    .parErr     (parErr),
    .protoErr   (protoErr),
    .errClear   (errClear),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cell-side frame, index 0 sent first: start, addr LSB-first, data LSB-first, parity.
  function automatic logic [29:0] inj_frame(input logic [11:0] a, input logic [15:0] d, input logic flip);
    logic [29:0] f;
    f[0]     = 1'b1;
    f[12:1]  = a;
    f[28:13] = d;
    f[29]    = (^{a, d}) ^ flip;
    return f;
  endfunction

  task automatic send_bit(input logic b);
    routerData = b;
    latch      = 1'b1;
    tick();
    latch      = 1'b0;
    routerData = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; latch = 1'b0; routerData = 1'b0; errClear = 1'b0;
    bus.injReady = 1'b0; bus.ejValid = 1'b0; bus.ejData = '0;
    tick(); tick();
    vec_cnt++; if (handshake !== 1'b1) begin miss_cnt++; $display("FAIL rst_handshake: got %b exp 1", handshake); end
    vec_cnt++; if (routerIn !== 1'b0) begin miss_cnt++; $display("FAIL rst_routerIn: got %b exp 0", routerIn); end
    vec_cnt++; if (bus.injValid !== 1'b0) begin miss_cnt++; $display("FAIL rst_injValid: got %b exp 0", bus.injValid); end
    vec_cnt++; if (bus.ejReady !== 1'b0) begin miss_cnt++; $display("FAIL rst_ejReady: got %b exp 0", bus.ejReady); end
    vec_cnt++; if (bus.injAddr !== 12'h000) begin miss_cnt++; $display("FAIL rst_injAddr: got %h exp 000", bus.injAddr); end
    vec_cnt++; if (bus.injData !== 16'h0000) begin miss_cnt++; $display("FAIL rst_injData: got %h exp 0000", bus.injData); end
    vec_cnt++; if (parErr !== 1'b0) begin miss_cnt++; $display("FAIL rst_parErr: got %b exp 0", parErr); end
    vec_cnt++; if (protoErr !== 1'b0) begin miss_cnt++; $display("FAIL rst_protoErr: got %b exp 0", protoErr); end
    reset = 1'b0;
    tick();
    vec_cnt++; if (bus.ejReady !== 1'b1) begin miss_cnt++; $display("FAIL post_rst_ejReady: got %b exp 1", bus.ejReady); end
  endtask

  task automatic test_inject();
    logic [29:0] f;
    f = inj_frame(12'h0A5, 16'h1234, 1'b0);
    bus.injReady = 1'b1;
    send_bit(f[0]);
    vec_cnt++; if (handshake !== 1'b0) begin miss_cnt++; $display("FAIL inj_hs_drop: got %b exp 0", handshake); end
    for (int i = 1; i < 30; i++) send_bit(f[i]);
    vec_cnt++; if (bus.injValid !== 1'b1) begin miss_cnt++; $display("FAIL inj_valid: got %b exp 1", bus.injValid); end
    vec_cnt++; if (bus.injAddr !== 12'h0A5) begin miss_cnt++; $display("FAIL inj_addr: got %h exp 0a5", bus.injAddr); end
    vec_cnt++; if (bus.injData !== 16'h1234) begin miss_cnt++; $display("FAIL inj_data: got %h exp 1234", bus.injData); end
    tick();
    vec_cnt++; if (bus.injValid !== 1'b0) begin miss_cnt++; $display("FAIL inj_valid_once: got %b exp 0", bus.injValid); end
    vec_cnt++; if (handshake !== 1'b1) begin miss_cnt++; $display("FAIL inj_hs_back: got %b exp 1", handshake); end
  endtask

  task automatic test_parity_err();
    logic [29:0] f;
    f = inj_frame(12'h0A5, 16'h1234, 1'b1);
    bus.injReady = 1'b1;
    for (int i = 0; i < 30; i++) send_bit(f[i]);
    vec_cnt++; if (bus.injValid !== 1'b0) begin miss_cnt++; $display("FAIL par_no_valid: got %b exp 0", bus.injValid); end
    vec_cnt++; if (parErr !== 1'b1) begin miss_cnt++; $display("FAIL par_err_set: got %b exp 1", parErr); end
    vec_cnt++; if (handshake !== 1'b1) begin miss_cnt++; $display("FAIL par_hs_back: got %b exp 1", handshake); end
    tick();
    vec_cnt++; if (parErr !== 1'b1) begin miss_cnt++; $display("FAIL par_err_sticky: got %b exp 1", parErr); end
    errClear = 1'b1; tick(); errClear = 1'b0;
    vec_cnt++; if (parErr !== 1'b0) begin miss_cnt++; $display("FAIL par_err_clear: got %b exp 0", parErr); end
  endtask

  task automatic test_backpressure();
    logic [29:0] f;
    f = inj_frame(12'h0A5, 16'h1234, 1'b0);
    bus.injReady = 1'b0;
    for (int i = 0; i < 30; i++) send_bit(f[i]);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) send_bit(1'b1); else tick();
      vec_cnt++;
      if (bus.injValid !== 1'b1 || bus.injAddr !== 12'h0A5 || bus.injData !== 16'h1234) begin
        miss_cnt++;
        $display("FAIL bp_hold c=%0d: got v=%b a=%h d=%h exp v=1 a=0a5 d=1234", c, bus.injValid, bus.injAddr, bus.injData);
      end
    end
    vec_cnt++; if (protoErr !== 1'b1) begin miss_cnt++; $display("FAIL bp_protoErr: got %b exp 1", protoErr); end
    vec_cnt++; if (handshake !== 1'b0) begin miss_cnt++; $display("FAIL bp_hs_low: got %b exp 0", handshake); end
    bus.injReady = 1'b1;
    tick();
    vec_cnt++; if (bus.injValid !== 1'b0) begin miss_cnt++; $display("FAIL bp_delivered: got %b exp 0", bus.injValid); end
    vec_cnt++; if (handshake !== 1'b1) begin miss_cnt++; $display("FAIL bp_hs_back: got %b exp 1", handshake); end
    errClear = 1'b1; tick(); errClear = 1'b0;
    vec_cnt++; if (protoErr !== 1'b0) begin miss_cnt++; $display("FAIL bp_proto_clear: got %b exp 0", protoErr); end
  endtask

  task automatic test_eject();
    // 0x8001 on the wire, index 0 first: 1 (start), 1, fourteen 0s, 1, 0 (parity), 0 (idle)
    logic [18:0] exp;
    logic        prev, l, e;
    int          k;
    exp = 19'b001_00000000000000_11;
    bus.ejData = 16'h8001; bus.ejValid = 1'b1;
    vec_cnt++; if (bus.ejReady !== 1'b1) begin miss_cnt++; $display("FAIL ej_ready_idle: got %b exp 1", bus.ejReady); end
    tick();
    bus.ejValid = 1'b0;
    vec_cnt++; if (bus.ejReady !== 1'b0) begin miss_cnt++; $display("FAIL ej_ready_drop: got %b exp 0", bus.ejReady); end
    k = 0; prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      l = (c % 3 == 2);
      latch = l;
      tick();
      latch = 1'b0;
      e = l ? ((k < 19) ? exp[k] : 1'b0) : prev;
      vec_cnt++;
      if (routerIn !== e) begin
        miss_cnt++;
        $display("FAIL ej_bit c=%0d k=%0d latch=%b: got %b exp %b", c, k, l, routerIn, e);
      end
      if (l) k++;
      prev = e;
    end
    vec_cnt++; if (bus.ejReady !== 1'b1) begin miss_cnt++; $display("FAIL ej_ready_back: got %b exp 1", bus.ejReady); end
  endtask

  task automatic test_concurrent();
    // 0x00FF on the wire: start, eight 1s, eight 0s, parity 0, idle 0
    logic [18:0] eexp;
    logic [29:0] f;
    logic        prev, l, e;
    int          k, pulses;
    eexp = 19'b00_00000000_11111111_1;
    f    = inj_frame(12'h001, 16'hFFFF, 1'b0);
    bus.injReady = 1'b1;
    bus.ejData = 16'h00FF; bus.ejValid = 1'b1;
    tick();
    bus.ejValid = 1'b0;
    k = 0; pulses = 0; prev = 1'b0;
    for (int c = 0; c < 66; c++) begin
      l = (c % 2 == 1);
      latch = l;
      routerData = (l && k < 30) ? f[k] : 1'b0;
      tick();
      latch = 1'b0; routerData = 1'b0;
      e = l ? ((k < 19) ? eexp[k] : 1'b0) : prev;
      vec_cnt++;
      if (routerIn !== e) begin
        miss_cnt++;
        $display("FAIL cc_ej_bit c=%0d k=%0d: got %b exp %b", c, k, routerIn, e);
      end
      if (l && k == 29) begin
        vec_cnt++;
        if (bus.injValid !== 1'b1 || bus.injAddr !== 12'h001 || bus.injData !== 16'hFFFF) begin
          miss_cnt++;
          $display("FAIL cc_inj: got v=%b a=%h d=%h exp v=1 a=001 d=ffff", bus.injValid, bus.injAddr, bus.injData);
        end
      end
      if (bus.injValid === 1'b1) pulses++;
      if (l) k++;
      prev = e;
    end
    vec_cnt++; if (pulses != 1) begin miss_cnt++; $display("FAIL cc_inj_pulses: got %0d exp 1", pulses); end
    vec_cnt++; if (bus.ejReady !== 1'b1) begin miss_cnt++; $display("FAIL cc_ej_ready: got %b exp 1", bus.ejReady); end
  endtask

  task automatic test_reset_mid();
    logic [29:0] f;
    bus.injReady = 1'b1;
    bus.ejData = 16'hA5A5; bus.ejValid = 1'b1;
    tick();
    bus.ejValid = 1'b0;
    f = inj_frame(12'h3C3, 16'h5A5A, 1'b0);
    // 15 latches: injector two bits into data, serializer has just sent data bit 13 (a 1)
    for (int i = 0; i < 15; i++) send_bit(f[i]);
    vec_cnt++; if (routerIn !== 1'b1) begin miss_cnt++; $display("FAIL mid_routerIn_pre: got %b exp 1", routerIn); end
    reset = 1'b1;
    tick();
    vec_cnt++;
    if (handshake !== 1'b1 || routerIn !== 1'b0 || bus.injValid !== 1'b0 || bus.ejReady !== 1'b0 ||
        parErr !== 1'b0 || protoErr !== 1'b0 || bus.injAddr !== 12'h000 || bus.injData !== 16'h0000) begin
      miss_cnt++;
      $display("FAIL mid_rst_outputs: got hs=%b ri=%b iv=%b er=%b pe=%b pr=%b a=%h d=%h exp 1 0 0 0 0 0 000 0000",
               handshake, routerIn, bus.injValid, bus.ejReady, parErr, protoErr, bus.injAddr, bus.injData);
    end
    reset = 1'b0;
    tick();
    vec_cnt++; if (bus.ejReady !== 1'b1) begin miss_cnt++; $display("FAIL mid_ej_ready: got %b exp 1", bus.ejReady); end
    f = inj_frame(12'h0A5, 16'h1234, 1'b0);
    for (int i = 0; i < 30; i++) send_bit(f[i]);
    vec_cnt++;
    if (bus.injValid !== 1'b1 || bus.injAddr !== 12'h0A5 || bus.injData !== 16'h1234) begin
      miss_cnt++;
      $display("FAIL mid_clean_frame: got v=%b a=%h d=%h exp v=1 a=0a5 d=1234", bus.injValid, bus.injAddr, bus.injData);
    end
    vec_cnt++; if (routerIn !== 1'b0) begin miss_cnt++; $display("FAIL mid_routerIn_idle: got %b exp 0", routerIn); end
    tick();
    vec_cnt++; if (bus.injValid !== 1'b0) begin miss_cnt++; $display("FAIL mid_clean_done: got %b exp 0", bus.injValid); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_inject();
    test_parity_err();
    test_backpressure();
    test_eject();
    test_concurrent();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
